// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI engine arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

  typedef enum logic {OWN_INERT, OWN_A2D} owner_t;

  localparam logic [15:0] TMO_RESP = 16'hFFFF;

endpackage

// File: rtl/spi_req_buf.sv
// One-deep command buffer for a single requester of the shared SPI engine.
module spi_req_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] new_cmd,
  input  logic        in_flight,
  input  logic        grant,
  output logic        pend,
  output logic [15:0] held_cmd,
  output logic        drop
);

  // A command already queued or on the engine must not be overwritten.
  assign drop = req && (pend || in_flight);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      held_cmd <= 16'h0000;
    end else if (req && !drop) begin
      pend     <= 1'b1;
      held_cmd <= new_cmd;
    end else if (grant) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Shares one SPI transaction engine between the inertial and A2D interfaces,
// inertial first, with A2D protected from starvation after STARVE_LIM grants.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 3,
  parameter int unsigned TMO_CYC    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inert_req,
  input  logic [15:0] inert_cmd,
  output logic        inert_done,
  output logic [15:0] inert_resp,
  input  logic        a2d_req,
  input  logic [15:0] a2d_cmd,
  output logic        a2d_done,
  output logic [15:0] a2d_resp,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [15:0] rd_data,
  output logic        owner,
  output logic        busy,
  output logic        ovr,
  output logic        tmo
);

  localparam int unsigned SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_CYC - 1);

  state_t        state_q;
  owner_t        owner_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [15:0]   cmd_q, inert_resp_q, a2d_resp_q;
  logic          wrt_q, busy_q, inert_done_q, a2d_done_q, ovr_q, tmo_q;

  logic          inert_pend, a2d_pend, inert_drop, a2d_drop;
  logic [15:0]   inert_held, a2d_held;
  logic          grant_inert, grant_a2d, starve_full;

  assign starve_full = (starve_q == STARVE_MAX);
  assign grant_a2d   = (state_q == IDLE) && a2d_pend && (!inert_pend || starve_full);
  assign grant_inert = (state_q == IDLE) && inert_pend && !(a2d_pend && starve_full);

  spi_req_buf u_inert_buf (
    .clk       (clk),
    .rst       (rst),
    .req       (inert_req),
    .new_cmd   (inert_cmd),
    .in_flight (busy_q && (owner_q == OWN_INERT)),
    .grant     (grant_inert),
    .pend      (inert_pend),
    .held_cmd  (inert_held),
    .drop      (inert_drop)
  );

  spi_req_buf u_a2d_buf (
    .clk       (clk),
    .rst       (rst),
    .req       (a2d_req),
    .new_cmd   (a2d_cmd),
    .in_flight (busy_q && (owner_q == OWN_A2D)),
    .grant     (grant_a2d),
    .pend      (a2d_pend),
    .held_cmd  (a2d_held),
    .drop      (a2d_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INERT;
      starve_q     <= '0;
      tmo_cnt_q    <= '0;
      cmd_q        <= 16'h0000;
      inert_resp_q <= 16'h0000;
      a2d_resp_q   <= 16'h0000;
      wrt_q        <= 1'b0;
      busy_q       <= 1'b0;
      inert_done_q <= 1'b0;
      a2d_done_q   <= 1'b0;
      ovr_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      wrt_q        <= 1'b0;
      inert_done_q <= 1'b0;
      a2d_done_q   <= 1'b0;
      tmo_q        <= 1'b0;
      ovr_q        <= inert_drop || a2d_drop;
      case (state_q)
        IDLE: begin
          if (grant_inert) begin
            owner_q <= OWN_INERT;
            cmd_q   <= inert_held;
            wrt_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
            if (a2d_pend && !starve_full) starve_q <= starve_q + 1'b1;
          end else if (grant_a2d) begin
            owner_q  <= OWN_A2D;
            cmd_q    <= a2d_held;
            wrt_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
            starve_q <= '0;
          end
        end
        ISSUE: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (spi_done || (tmo_cnt_q == TMO_LAST)) begin
            if (owner_q == OWN_A2D) begin
              a2d_resp_q <= spi_done ? rd_data : TMO_RESP;
              a2d_done_q <= 1'b1;
            end else begin
              inert_resp_q <= spi_done ? rd_data : TMO_RESP;
              inert_done_q <= 1'b1;
            end
            tmo_q   <= !spi_done;
            busy_q  <= 1'b0;
            state_q <= RETIRE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        RETIRE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inert_done = inert_done_q;
  assign inert_resp = inert_resp_q;
  assign a2d_done   = a2d_done_q;
  assign a2d_resp   = a2d_resp_q;
  assign wrt        = wrt_q;
  assign cmd        = cmd_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign ovr        = ovr_q;
  assign tmo        = tmo_q;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: per-cycle vector table plus starvation, timeout
// and reset-abort sequences.
module tb_spi_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inert_req = 1'b0, a2d_req = 1'b0, spi_done = 1'b0;
  logic [15:0] inert_cmd = '0, a2d_cmd = '0, rd_data = '0;
  logic        inert_done, a2d_done, wrt, owner, busy, ovr, tmo;
  logic [15:0] inert_resp, a2d_resp, cmd;

  int n_cmp = 0;
  int n_bad = 0;

  spi_arb #(.STARVE_LIM(3), .TMO_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .inert_req  (inert_req),
    .inert_cmd  (inert_cmd),
    .inert_done (inert_done),
    .inert_resp (inert_resp),
    .a2d_req    (a2d_req),
    .a2d_cmd    (a2d_cmd),
    .a2d_done   (a2d_done),
    .a2d_resp   (a2d_resp),
    .wrt        (wrt),
    .cmd        (cmd),
    .spi_done   (spi_done),
    .rd_data    (rd_data),
    .owner      (owner),
    .busy       (busy),
    .ovr        (ovr),
    .tmo        (tmo)
  );

  always #5 clk = ~clk;

  // Row: inputs driven during a cycle and outputs expected in that same cycle.
  // flags = {wrt, busy, owner, inert_done, a2d_done, ovr, tmo}
  typedef struct {
    logic        ireq;
    logic [15:0] icmd;
    logic        areq;
    logic [15:0] acmd;
    logic        sdone;
    logic [15:0] rdat;
    logic [6:0]  flags;
    logic [15:0] ecmd;
    logic [15:0] eiresp;
    logic [15:0] earesp;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(logic ir, logic [15:0] ic, logic ar, logic [15:0] ac,
                              logic sd, logic [15:0] rd, logic [6:0] fl,
                              logic [15:0] ec, logic [15:0] ei, logic [15:0] ea);
    vec_t v;
    v.ireq = ir; v.icmd = ic; v.areq = ar; v.acmd = ac; v.sdone = sd; v.rdat = rd;
    v.flags = fl; v.ecmd = ec; v.eiresp = ei; v.earesp = ea;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_wrt(input string name);
    int n;
    n = 0;
    while (wrt !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, {15'd0, wrt}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] act_f, mask;
    bit   [4:0] exp_own;

    vecs[0]  = mk(1, 16'hA400, 0, 0, 0, 0,         7'b0000000, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,                7'b0000000, 0, 16'h0000, 16'h0000);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,                7'b1100000, 16'hA400, 16'h0000, 16'h0000);
    vecs[3]  = mk(0, 0, 0, 0, 1, 16'h1234,         7'b0100000, 0, 16'h0000, 16'h0000);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,                7'b0001000, 0, 16'h1234, 16'h0000);
    vecs[5]  = mk(1, 16'h1111, 1, 16'h2222, 0, 0,  7'b0000000, 0, 16'h1234, 16'h0000);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,                7'b0000000, 0, 16'h1234, 16'h0000);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,                7'b1100000, 16'h1111, 16'h1234, 16'h0000);
    vecs[8]  = mk(0, 0, 0, 0, 1, 16'h0AAA,         7'b0100000, 0, 16'h1234, 16'h0000);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,                7'b0001000, 0, 16'h0AAA, 16'h0000);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,                7'b0000000, 0, 16'h0AAA, 16'h0000);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,                7'b1110000, 16'h2222, 16'h0AAA, 16'h0000);
    vecs[12] = mk(0, 0, 0, 0, 1, 16'h0BBB,         7'b0110000, 0, 16'h0AAA, 16'h0000);
    vecs[13] = mk(0, 0, 0, 0, 0, 0,                7'b0000100, 0, 16'h0AAA, 16'h0BBB);
    vecs[14] = mk(1, 16'h3333, 0, 0, 0, 0,         7'b0000000, 0, 16'h0AAA, 16'h0BBB);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,                7'b0000000, 0, 16'h0AAA, 16'h0BBB);
    vecs[16] = mk(1, 16'h4444, 0, 0, 0, 0,         7'b1100000, 16'h3333, 16'h0AAA, 16'h0BBB);
    vecs[17] = mk(0, 0, 0, 0, 1, 16'h5555,         7'b0100010, 0, 16'h0AAA, 16'h0BBB);
    vecs[18] = mk(1, 16'h6666, 0, 0, 0, 0,         7'b0001000, 0, 16'h5555, 16'h0BBB);
    vecs[19] = mk(1, 16'h7777, 0, 0, 0, 0,         7'b0000000, 0, 16'h5555, 16'h0BBB);
    vecs[20] = mk(0, 0, 0, 0, 0, 0,                7'b1100010, 16'h6666, 16'h5555, 16'h0BBB);
    vecs[21] = mk(0, 0, 0, 0, 1, 16'h0F0F,         7'b0100000, 0, 16'h5555, 16'h0BBB);
    vecs[22] = mk(0, 0, 0, 0, 0, 0,                7'b0001000, 0, 16'h0F0F, 16'h0BBB);
    vecs[23] = mk(0, 0, 0, 0, 1, 16'h9999,         7'b0000000, 0, 16'h0F0F, 16'h0BBB);
    vecs[24] = mk(0, 0, 0, 0, 0, 0,                7'b0000000, 0, 16'h0F0F, 16'h0BBB);
    vecs[25] = mk(0, 0, 0, 0, 0, 0,                7'b0000000, 0, 16'h0F0F, 16'h0BBB);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("reset flags", {9'd0, wrt, busy, owner, inert_done, a2d_done, ovr, tmo}, 16'd0);
    check("reset cmd", cmd, 16'h0000);
    check("reset inert_resp", inert_resp, 16'h0000);
    check("reset a2d_resp", a2d_resp, 16'h0000);
    rst = 1'b0;
    tick();

    // Vector table
    for (int i = 0; i < NV; i++) begin
      act_f = {wrt, busy, owner, inert_done, a2d_done, ovr, tmo};
      mask  = vecs[i].flags[5] ? 7'h7F : 7'b1101111;  // owner only meaningful while busy
      check($sformatf("row%0d flags", i), {9'd0, act_f & mask}, {9'd0, vecs[i].flags & mask});
      if (vecs[i].flags[6]) check($sformatf("row%0d cmd", i), cmd, vecs[i].ecmd);
      check($sformatf("row%0d inert_resp", i), inert_resp, vecs[i].eiresp);
      check($sformatf("row%0d a2d_resp", i), a2d_resp, vecs[i].earesp);
      inert_req = vecs[i].ireq;
      inert_cmd = vecs[i].icmd;
      a2d_req   = vecs[i].areq;
      a2d_cmd   = vecs[i].acmd;
      spi_done  = vecs[i].sdone;
      rd_data   = vecs[i].rdat;
      tick();
    end
    inert_req = 1'b0;
    a2d_req   = 1'b0;
    spi_done  = 1'b0;

    // Starvation: inertial re-requests on every done; 4th grant must be A2D
    exp_own   = 5'b01000;
    inert_cmd = 16'h1001;
    a2d_cmd   = 16'h2002;
    inert_req = 1'b1;
    a2d_req   = 1'b1;
    tick();
    inert_req = 1'b0;
    a2d_req   = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wait_wrt($sformatf("starve wrt %0d", g));
      check($sformatf("starve owner %0d", g), {15'd0, owner}, {15'd0, exp_own[g]});
      if (g == 3) check("starve a2d cmd", cmd, 16'h2002);
      tick();
      spi_done = 1'b1;
      rd_data  = 16'h0100 + 16'(g);
      tick();
      spi_done = 1'b0;
      check($sformatf("starve done %0d", g),
            {15'd0, exp_own[g] ? a2d_done : inert_done}, 16'd1);
      if (g < 3) begin
        inert_req = 1'b1;
        inert_cmd = 16'h1100 + 16'(g);
      end
      tick();
      inert_req = 1'b0;
    end

    // Timeout on an A2D transaction
    a2d_cmd = 16'hABCD;
    a2d_req = 1'b1;
    tick();
    a2d_req = 1'b0;
    wait_wrt("tmo wrt");
    check("tmo owner", {15'd0, owner}, 16'd1);
    repeat (16) tick();
    check("tmo early", {13'd0, tmo, a2d_done, busy}, 16'b001);
    tick();
    check("tmo pulse", {13'd0, tmo, a2d_done, busy}, 16'b110);
    check("tmo resp", a2d_resp, 16'hFFFF);
    tick();
    check("tmo after", {12'd0, tmo, a2d_done, busy, wrt}, 16'd0);

    // Reset mid-WAIT, followed by a stale spi_done
    inert_cmd = 16'h5A5A;
    inert_req = 1'b1;
    tick();
    inert_req = 1'b0;
    wait_wrt("rst wrt");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst abort", {12'd0, wrt, busy, inert_done, a2d_done}, 16'd0);
    check("rst inert_resp", inert_resp, 16'h0000);
    check("rst a2d_resp", a2d_resp, 16'h0000);
    spi_done = 1'b1;
    rd_data  = 16'h7777;
    tick();
    spi_done = 1'b0;
    check("stale done", {12'd0, wrt, busy, inert_done, a2d_done}, 16'd0);
    check("stale resp", inert_resp, 16'h0000);
    tick();
    check("stale done 2", {12'd0, wrt, busy, inert_done, a2d_done}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
